muldiv_div: RTL and testbench

- Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the combinational ALU in the execute stage. It takes the same ra/rb operands plus funct3, and returns one result through a valid/ready handshake.
- Radix-2 restoring algorithm: one quotient bit per cycle.
- Divide-by-zero and signed overflow are resolved on a fast path.

---
 rtl/muldiv_div.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_div.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_div.sv
// ---------------------------------------------------------------------------
// muldiv_div
//
// Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
// It lives beside the combinational ALU in execute. It produces one quotient
// bit per clock, so a normal divide takes 32 step cycles. Divide-by-zero and
// signed overflow (0x80000000 / -1) skip the iteration and finish right away.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid (accepted in IDLE unless kill is high)
//   in_ready   high only in IDLE
//   ra, rb     dividend (rs1) and divisor (rs2)
//   funct3     100=DIV 101=DIVU 110=REM 111=REMU (bits [1:0] decoded)
//   kill       synchronous flush of any in-flight operation
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts the result
//   out        quotient or remainder, chosen by funct3[1] at accept
//   busy       high in CALC or DONE
// ---------------------------------------------------------------------------
module muldiv_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ra,
    input  logic [XLEN-1:0] rb,
    input  logic [2:0]      funct3,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  div_q;
    logic             is_signed_q;
    logic             want_rem_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             fast_q;

    // funct3[2] is always 1 for this unit and carries no information.
    logic unused_funct3;
    assign unused_funct3 = funct3[2];

    // Decode of the incoming request. The absolute values use a plain 32-bit
    // two's-complement negate, so 0x80000000 maps to itself. That value is
    // still the correct magnitude when it is read as unsigned.
    logic            req_signed;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] ra_abs;
    logic [XLEN-1:0] rb_abs;
    logic            accept;

    assign req_signed = ~funct3[0];
    assign div_zero   = (rb == '0);
    assign sgn_ovf    = req_signed && (ra == {1'b1, {(XLEN-1){1'b0}}}) && (rb == '1);
    assign ra_abs     = (req_signed && ra[XLEN-1]) ? (~ra + 1'b1) : ra;
    assign rb_abs     = (req_signed && rb[XLEN-1]) ? (~rb + 1'b1) : rb;
    assign accept     = (state == IDLE) && in_valid && !kill;

    // One restoring step. The partial remainder is shifted left and takes the
    // next dividend bit from the top of the quotient register. A 33-bit
    // subtract exposes the borrow: bit 32 set means the trial went negative.
    logic [XLEN:0] trial;
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. kill overrides every other transition, including an
    // accept in IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = (div_zero || sgn_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
        end
    end

    // Datapath registers. Fast-path results are loaded straight into the
    // quotient/remainder registers, and fast_q suppresses the sign fix so the
    // remainder of a divide-by-zero comes back as the raw dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            is_signed_q <= 1'b0;
            want_rem_q  <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            fast_q      <= 1'b0;
        end else if (accept) begin
            cnt_q       <= '0;
            div_q       <= rb_abs;
            is_signed_q <= req_signed;
            want_rem_q  <= funct3[1];
            q_neg_q     <= req_signed && (ra[XLEN-1] ^ rb[XLEN-1]);
            r_neg_q     <= req_signed && ra[XLEN-1];
            if (div_zero) begin
                quo_q  <= '1;
                rem_q  <= ra;
                fast_q <= 1'b1;
            end else if (sgn_ovf) begin
                quo_q  <= {1'b1, {(XLEN-1){1'b0}}};
                rem_q  <= '0;
                fast_q <= 1'b1;
            end else begin
                quo_q  <= ra_abs;
                rem_q  <= '0;
                fast_q <= 1'b0;
            end
        end else if (state == CALC && !kill) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!trial[XLEN]) begin
                rem_q <= trial[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Output decode. The result is formed combinationally from registered
    // state, so it cannot change while DONE waits on out_ready. out is zero
    // outside DONE, which also makes it read zero during reset.
    logic [XLEN-1:0] final_quo;
    logic [XLEN-1:0] final_rem;

    always_comb begin
        final_quo = quo_q;
        final_rem = rem_q;
        if (is_signed_q && q_neg_q && !fast_q) begin
            final_quo = ~quo_q + 1'b1;
        end
        if (is_signed_q && r_neg_q && !fast_q) begin
            final_rem = ~rem_q + 1'b1;
        end
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out       = '0;
        if (state == DONE) begin
            out = want_rem_q ? final_rem : final_quo;
        end
    end

endmodule

// File: tb/tb_muldiv_div.sv
// ---------------------------------------------------------------------------
// tb_muldiv_div
//
// Self-checking bench for muldiv_div. Expected results come from a
// behavioural model written with plain SystemVerilog arithmetic, following
// the RISC-V divide rules (truncating signed division, the divide-by-zero
// results and the overflow result).
// ---------------------------------------------------------------------------
module tb_muldiv_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  funct3;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int n_vec;
    int n_mis;

    muldiv_div #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ra        (ra),
        .rb        (rb),
        .funct3    (funct3),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: if the bench ever stalls, report it and stop.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: the architectural result of the operation.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
        if (!f3[0]) begin
            sa = a;
            sb = b;
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    // Expected cycles from the accept edge until out_valid is seen.
    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Runs one full transaction. Operands are scrambled after the accept edge
    // so that any late sampling of them would corrupt the result.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit tmo);
        int w;
        tmo = 1'b0;
        res = '0;
        lat = 0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        in_valid  = 1'b1;
        funct3    = f3;
        ra        = a;
        rb        = b;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ra       = $urandom;
        rb       = $urandom;
        funct3   = 3'($urandom);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        res       = out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out !== 32'd0) begin
            n_mis++;
            $display("[TB] FAIL reset_outputs: actual rdy/vld/busy=%b out=%h required 100 out=00000000",
                     {in_ready, out_valid, busy}, out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_mis++;
            $display("[TB] FAIL idle_after_reset: actual rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl[12];
        logic [31:0] res;
        int          lat;
        bit          tmo;
        tbl[0]  = '{3'b101, 32'd100,          32'd7,          32'd14,         32};
        tbl[1]  = '{3'b111, 32'd100,          32'd7,          32'd2,          32};
        tbl[2]  = '{3'b100, 32'hFFFF_FF9C,    32'd7,          32'hFFFF_FFF2,  32};
        tbl[3]  = '{3'b110, 32'hFFFF_FF9C,    32'd7,          32'hFFFF_FFFE,  32};
        tbl[4]  = '{3'b110, 32'd100,          32'hFFFF_FFF9,  32'd2,          32};
        tbl[5]  = '{3'b100, 32'd5,            32'd0,          32'hFFFF_FFFF,  0};
        tbl[6]  = '{3'b110, 32'd5,            32'd0,          32'd5,          0};
        tbl[7]  = '{3'b101, 32'h8000_0000,    32'd0,          32'hFFFF_FFFF,  0};
        tbl[8]  = '{3'b100, 32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,  0};
        tbl[9]  = '{3'b110, 32'h8000_0000,    32'hFFFF_FFFF,  32'd0,          0};
        tbl[10] = '{3'b101, 32'h8000_0000,    32'd2,          32'h4000_0000,  32};
        tbl[11] = '{3'b110, 32'hFFFF_FFFB,    32'd0,          32'hFFFF_FFFB,  0};
        foreach (tbl[i]) begin
            do_op(tbl[i].f3, tbl[i].a, tbl[i].b, res, lat, tmo);
            n_vec++;
            if (tmo !== 1'b0) begin
                n_mis++;
                $display("[TB] FAIL directed_%0d_timeout: actual no result required result", i);
            end else begin
                if (res !== tbl[i].exp) begin
                    n_mis++;
                    $display("[TB] FAIL directed_%0d_value: actual=%h required=%h", i, res, tbl[i].exp);
                end
                n_vec++;
                if (lat !== tbl[i].lat) begin
                    n_mis++;
                    $display("[TB] FAIL directed_%0d_latency: actual=%0d required=%0d", i, lat, tbl[i].lat);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 40; i++) begin
            f3 = {1'b1, 2'($urandom)};
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: begin a = 32'h8000_0000; b = 32'($urandom_range(1, 4)); end
                default: ;
            endcase
            do_op(f3, a, b, res, lat, tmo);
            n_vec++;
            if (tmo !== 1'b0) begin
                n_mis++;
                $display("[TB] FAIL random_%0d_timeout: actual no result required result", i);
            end else if (res !== model(f3, a, b) || lat !== model_lat(f3, a, b)) begin
                n_mis++;
                $display("[TB] FAIL random_%0d f3=%b a=%h b=%h: actual=%h lat=%0d required=%h lat=%0d",
                         i, f3, a, b, res, lat, model(f3, a, b), model_lat(f3, a, b));
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        funct3    = 3'b101;
        ra        = 32'd1000;
        rb        = 32'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({out_valid, in_ready} !== 2'b10 || out !== 32'd100) begin
                n_mis++;
                $display("[TB] FAIL hold_cycle_%0d: actual vld/rdy=%b out=%h required 10 out=00000064",
                         c, {out_valid, in_ready}, out);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_mis++;
            $display("[TB] FAIL release_to_idle: actual vld/rdy=%b required 01", {out_valid, in_ready});
        end
        in_valid = 1'b1;
        funct3   = 3'b101;
        ra       = 32'd77;
        rb       = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_mis++;
            $display("[TB] FAIL back_to_back_accept: actual busy=%b required 1", busy);
        end
        w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        n_vec++;
        if (out_valid !== 1'b1 || out !== 32'd11) begin
            n_mis++;
            $display("[TB] FAIL back_to_back_value: actual vld=%b out=%h required 1 out=0000000b", out_valid, out);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int          lat;
        bit          tmo;
        bit          seen;
        in_valid = 1'b1;
        funct3   = 3'b101;
        ra       = 32'h1234_5678;
        rb       = 32'd3;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_mis++;
            $display("[TB] FAIL kill_to_idle: actual rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_mis++;
            $display("[TB] FAIL kill_no_result: actual out_valid seen=%b required 0", seen);
        end
        kill     = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        kill     = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if ({in_ready, busy} !== 2'b10) begin
            n_mis++;
            $display("[TB] FAIL kill_blocks_accept: actual rdy/busy=%b required 10", {in_ready, busy});
        end
        do_op(3'b101, 32'hFFFF_FFFF, 32'h10, res, lat, tmo);
        n_vec++;
        if (tmo !== 1'b0 || res !== 32'h0FFF_FFFF) begin
            n_mis++;
            $display("[TB] FAIL after_kill_value: actual=%h timeout=%b required=0fffffff timeout=0", res, tmo);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          tmo;
        in_valid = 1'b1;
        funct3   = 3'b100;
        ra       = 32'd999;
        rb       = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out !== 32'd0) begin
            n_mis++;
            $display("[TB] FAIL reset_mid_calc: actual rdy/vld/busy=%b out=%h required 100 out=00000000",
                     {in_ready, out_valid, busy}, out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(3'b110, 32'hFFFF_FC19, 32'd4, res, lat, tmo);
        n_vec++;
        if (tmo !== 1'b0 || res !== model(3'b110, 32'hFFFF_FC19, 32'd4)) begin
            n_mis++;
            $display("[TB] FAIL after_reset_value: actual=%h timeout=%b required=%h timeout=0",
                     res, tmo, model(3'b110, 32'hFFFF_FC19, 32'd4));
        end
    endtask

    initial begin
        n_vec     = 0;
        n_mis     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ra        = '0;
        rb        = '0;
        funct3    = 3'b101;
        kill      = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
